byte_word_rx: RTL
=================

// Module: byte_word_rx
// PURPOSE
//   Receive end of the 8-bit registered byte stream. Accepts bytes on a valid/ready
//   handshake, packs them into BYTES_PER_WORD-wide words, and presents each word with
//   per-byte keep on a valid/ready output. A packet ends early on in_last (partial word).
//   Sits between the byte-stream producer and word-wide consumers (buffers, bus masters).
// PARAMETERS
//   BYTES_PER_WORD  4  bytes per output word, >=2
//   LITTLE_ENDIAN   1  1: first byte -> lane 0 (bits 7:0); 0: first byte -> top lane
// PORTS
//   clk         in   1                  clock
//   rst_n       in   1                  reset, synchronous, active-low
//   in_valid    in   1                  byte available
//   in_ready    out  1                  block accepts byte this cycle
//   in_data     in   8                  byte
//   in_last     in   1                  byte is last of packet
//   out_valid   out  1                  word available
//   out_ready   in   1                  consumer accepts word
//   out_data    out  8*BYTES_PER_WORD   packed word; unused lanes are 0
//   out_keep    out  BYTES_PER_WORD     1 per valid lane
//   out_last    out  1                  word holds last byte of packet
//   stat_words  out  16                 count of words handed off; wraps at 0xFFFF->0
// BEHAVIOUR
//   - Reset: out_valid=0, out_data=0, out_keep=0, out_last=0, stat_words=0, lane idx=0,
//     accumulator cleared, state=FILL. Reset mid-packet discards partial word and any
//     pending/held word; no output transfer is generated for it.
//   - Byte accept = in_valid & in_ready. Accepted byte written to lane idx (mirrored
//     when LITTLE_ENDIAN=0); keep bit set; idx increments.
//   - Word complete on accept when idx==BYTES_PER_WORD-1 or in_last=1.
//   - FSM: FILL: in_ready=1. On completion, if out register free (!out_valid |
//     out_ready) transfer accumulator to out register next edge, idx=0, acc cleared,
//     stay FILL; else latch word in accumulator and go PEND.
//     PEND: in_ready=0. When out register free, transfer, idx=0, -> FILL.
//   - Latency: out_valid rises the cycle after the completing byte is accepted.
//     Full throughput (1 byte/cycle, 1 word per N cycles) sustained with out_ready=1.
//   - Output: out_data/keep/last stable while out_valid & !out_ready. out_valid drops
//     after handshake unless a new word loads in the same edge (back-to-back allowed).
//   - in_last on lane 0: word with keep=0...01, out_last=1. in_last on final lane:
//     full keep, out_last=1. Next byte starts a new word at lane 0.
//   - in_valid without in_ready: byte ignored, producer holds. in_data ignored when
//     !in_valid. stat_words increments on each out_valid & out_ready.
// STRUCTURE
//   - Shared package byte_stream_pkg: BYTE_W=8 constant, rx_state_t enum {FILL,PEND}.
//   - Single module; lane-write/mirror as a function in the package, no sub-module.
// TESTING
//   - Reset held, in_valid=1 -> in_ready=1, out_valid=0, stat_words=0 throughout.
//   - Bytes 11,22,33,44 back-to-back, out_ready=1, LE -> out_data=0x44332211, keep=F,
//     last=0, out_valid 1 cycle after byte 44; stat_words=1.
//   - Bytes AA,BB with in_last on BB -> out_data=0x0000BBAA, keep=3, out_last=1.
//   - out_ready=0, 8 bytes streamed -> first word held stable, second word goes PEND,
//     in_ready=0 after 8th byte; out_ready=1 -> both words delivered in order.
//   - LITTLE_ENDIAN=0, bytes 11,22,33,44 -> out_data=0x11223344.
//   - rst_n low after 2 bytes of a word -> no output; next 4 bytes form clean word.

Source files
------------

// File: rtl/byte_stream_pkg.sv
// byte_stream_pkg: shared byte-stream constants, receive FSM states and lane mapping.
package byte_stream_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic {FILL, PEND} rx_state_t;
  // Maps arrival order to physical lane; big-endian puts the first byte in the top lane.
  function automatic int unsigned lane_of(int unsigned idx, int unsigned n, bit le);
    return le ? idx : n - 1 - idx;
  endfunction
endpackage

// File: rtl/byte_word_rx.sv
// byte_word_rx: packs a valid/ready byte stream into keep-qualified words, ending early on in_last.
module byte_word_rx
  import byte_stream_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter bit LITTLE_ENDIAN  = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [BYTE_W-1:0]                in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] out_data,
  output logic [BYTES_PER_WORD-1:0]        out_keep,
  output logic                             out_last,
  output logic [15:0]                      stat_words
);
  localparam int W  = BYTE_W * BYTES_PER_WORD;
  localparam int IW = $clog2(BYTES_PER_WORD);
  rx_state_t                 state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [W-1:0]              acc_q, acc_d, acc_w, out_data_q, out_data_d;
  logic [BYTES_PER_WORD-1:0] keep_q, keep_d, keep_w, out_keep_q, out_keep_d;
  logic                      last_q, last_d, out_last_q, out_last_d, out_valid_q, out_valid_d;
  logic [15:0]               stat_q, stat_d;
  logic                      accept, done, free, load, pend;
  int unsigned               lane;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_keep   = out_keep_q;
  assign out_last   = out_last_q;
  assign stat_words = stat_q;
  always_comb begin
    lane        = lane_of(32'(idx_q), BYTES_PER_WORD, LITTLE_ENDIAN);
    acc_w       = acc_q | (W'(in_data) << (BYTE_W * lane));
    keep_w      = keep_q | (BYTES_PER_WORD'(1) << lane);
    pend        = state_q == PEND;
    in_ready    = !pend;
    accept      = in_valid & in_ready;
    done        = accept & (in_last | idx_q == IW'(BYTES_PER_WORD - 1));
    free        = !out_valid_q | out_ready;
    load        = free & (done | pend);
    state_d     = state_q;
    idx_d       = accept ? idx_q + IW'(1) : idx_q;
    acc_d       = accept ? acc_w : acc_q;
    keep_d      = accept ? keep_w : keep_q;
    last_d      = accept ? in_last : last_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q & !out_ready;
    stat_d      = stat_q + 16'(out_valid_q & out_ready);
    if (done & !free) state_d = PEND;
    // A completed word skips the accumulator when the output register can take it directly.
    if (load) begin
      out_data_d  = pend ? acc_q : acc_w;
      out_keep_d  = pend ? keep_q : keep_w;
      out_last_d  = pend ? last_q : in_last;
      out_valid_d = 1'b1;
      acc_d       = '0;
      keep_d      = '0;
      last_d      = 1'b0;
      idx_d       = '0;
      state_d     = FILL;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FILL;
      idx_q       <= '0;
      acc_q       <= '0;
      keep_q      <= '0;
      last_q      <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      stat_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      keep_q      <= keep_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      stat_q      <= stat_d;
    end
  end
endmodule
